// File: rtl/iob_eth_mii_mgmt.sv
// MDIO/MDC management master: preamble, command, turnaround and data slots for PHY read/write/scan.
// Frame starts the cycle after command acceptance; rd/wr pulses are dropped while busy, cke_i low freezes everything.
module iob_eth_mii_mgmt #(
   parameter int CLKDIV_W     = 8,
   parameter int PREAMBLE_LEN = 32
) (
   input  logic                clk_i,
   input  logic                cke_i,
   input  logic                rst_i,
   input  logic [CLKDIV_W-1:0] clkdiv_i,
   input  logic                no_pre_i,
   input  logic                scan_stat_i,
   input  logic                rd_stat_i,
   input  logic                wr_ctrl_i,
   input  logic [4:0]          fiad_i,
   input  logic [4:0]          rgad_i,
   input  logic [15:0]         ctrl_data_i,
   output logic [15:0]         prsd_o,
   output logic                busy_o,
   output logic                nvalid_o,
   output logic                linkfail_o,
   output logic                mdc_o,
   output logic                mdo_o,
   output logic                mdo_en_o,
   input  logic                mdi_i
);

   localparam int DIV_W = CLKDIV_W + 1;
   localparam int BIT_W = (PREAMBLE_LEN > 32) ? $clog2(PREAMBLE_LEN) : 5;

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_CMD, S_TA, S_DATA, S_END} state_t;

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [CLKDIV_W-1:0] half_q, half_d;
   logic [31:0]         sh_q, sh_d;
   logic [15:0]         rx_q, rx_d;
   logic [15:0]         prsd_q, prsd_d;
   logic                op_wr_q, op_wr_d;
   logic                scan_frm_q, scan_frm_d;
   logic                link_reg_q, link_reg_d;
   logic                linkfail_q, linkfail_d;
   logic                nvalid_q, nvalid_d;
   logic                scan_prev_q, scan_prev_d;

   logic [CLKDIV_W-1:0] half_new;
   logic [DIV_W-1:0]    half_ext;
   logic [DIV_W-1:0]    last_div;
   logic                slot_end;
   logic                in_frame;
   logic                start;

   always_comb begin
      half_new = clkdiv_i >> 1;
      if (half_new == '0) half_new = CLKDIV_W'(1);
      half_ext = {1'b0, half_q};
      last_div = {half_q, 1'b0} - DIV_W'(1);
      slot_end = (div_q == last_div);
      in_frame = state_q inside {S_PRE, S_CMD, S_TA, S_DATA};
      start    = wr_ctrl_i || rd_stat_i || scan_stat_i;
   end

   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      bit_d       = bit_q;
      half_d      = half_q;
      sh_d        = sh_q;
      rx_d        = rx_q;
      prsd_d      = prsd_q;
      op_wr_d     = op_wr_q;
      scan_frm_d  = scan_frm_q;
      link_reg_d  = link_reg_q;
      linkfail_d  = linkfail_q;
      nvalid_d    = nvalid_q;
      scan_prev_d = scan_stat_i;

      if (state_q == S_IDLE) begin
         if (start) begin
            state_d    = no_pre_i ? S_CMD : S_PRE;
            div_d      = '0;
            bit_d      = '0;
            half_d     = half_new;
            op_wr_d    = wr_ctrl_i;
            scan_frm_d = !wr_ctrl_i && !rd_stat_i;
            link_reg_d = (rgad_i == 5'd1);
            sh_d       = {2'b01, (wr_ctrl_i ? 2'b01 : 2'b10), fiad_i, rgad_i,
                          (wr_ctrl_i ? 2'b10 : 2'b00), (wr_ctrl_i ? ctrl_data_i : 16'h0000)};
         end
      end else begin
         div_d = slot_end ? '0 : div_q + DIV_W'(1);
         // Sample on the cycle MDC goes high so the value is in rx_d even when H = 1.
         if (state_q == S_DATA && !op_wr_q && div_q == half_ext)
            rx_d = {rx_q[14:0], mdi_i};
         if (slot_end) begin
            bit_d = bit_q + BIT_W'(1);
            if (state_q inside {S_CMD, S_TA, S_DATA})
               sh_d = {sh_q[30:0], 1'b0};
            case (state_q)
               S_PRE: if (bit_q == BIT_W'(PREAMBLE_LEN - 1)) begin
                  state_d = S_CMD;
                  bit_d   = '0;
               end
               S_CMD: if (bit_q == BIT_W'(13)) begin
                  state_d = S_TA;
                  bit_d   = '0;
               end
               S_TA: if (bit_q == BIT_W'(1)) begin
                  state_d = S_DATA;
                  bit_d   = '0;
               end
               S_DATA: if (bit_q == BIT_W'(15)) begin
                  state_d = S_END;
                  bit_d   = '0;
                  if (!op_wr_q) begin
                     prsd_d = rx_d;
                     if (link_reg_q) linkfail_d = ~rx_d[2];
                     if (scan_frm_q) nvalid_d = 1'b0;
                  end
               end
               S_END: state_d = S_IDLE;
               default: state_d = S_IDLE;
            endcase
         end
      end

      // A fresh scan request outranks a same-cycle scan completion.
      if (scan_stat_i && !scan_prev_q) nvalid_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         div_q       <= '0;
         bit_q       <= '0;
         half_q      <= '0;
         sh_q        <= '0;
         rx_q        <= '0;
         prsd_q      <= '0;
         op_wr_q     <= 1'b0;
         scan_frm_q  <= 1'b0;
         link_reg_q  <= 1'b0;
         linkfail_q  <= 1'b0;
         nvalid_q    <= 1'b0;
         scan_prev_q <= 1'b0;
      end else if (cke_i) begin
         state_q     <= state_d;
         div_q       <= div_d;
         bit_q       <= bit_d;
         half_q      <= half_d;
         sh_q        <= sh_d;
         rx_q        <= rx_d;
         prsd_q      <= prsd_d;
         op_wr_q     <= op_wr_d;
         scan_frm_q  <= scan_frm_d;
         link_reg_q  <= link_reg_d;
         linkfail_q  <= linkfail_d;
         nvalid_q    <= nvalid_d;
         scan_prev_q <= scan_prev_d;
      end
   end

   assign busy_o     = (state_q != S_IDLE);
   assign mdc_o      = in_frame && (div_q >= half_ext);
   assign mdo_en_o   = (state_q == S_PRE) || (state_q == S_CMD) ||
                       (((state_q == S_TA) || (state_q == S_DATA)) && op_wr_q);
   assign mdo_o      = mdo_en_o && ((state_q == S_PRE) || sh_q[31]);
   assign prsd_o     = prsd_q;
   assign nvalid_o   = nvalid_q;
   assign linkfail_o = linkfail_q;

endmodule

// File: doc/iob_eth_mii_mgmt.md
Name: iob_eth_mii_mgmt

Overview:
MII management (MDIO/MDC) master for the Ethernet core. It executes the PHY register read, write and scan commands that software issues through the MIIMODER, MIICOMMAND, MIIADDRESS and MIITX_DATA registers. It returns MIIRX_DATA and the MIISTATUS bits (NVALID, BUSY, LINKFAIL), which replace the current hardwired-zero status. It sits in the system clock domain beside the swreg block and drives the PHY MDC/MDIO pins through an external tristate buffer.

Parameters:
CLKDIV_W, 8, width of MDC divider field (MIIMODER[7:0])
PREAMBLE_LEN, 32, number of preamble '1' bits sent when preamble is enabled

Ports:
clk_i  input  1  system clock
cke_i  input  1  clock enable; low freezes all state and outputs
rst_i  input  1  synchronous active-high reset
clkdiv_i  input  CLKDIV_W  MDC divider (MIIMODER[7:0])
no_pre_i  input  1  suppress preamble (MIIMODER[8])
scan_stat_i  input  1  continuous status scan enable (MIICOMMAND[0], level)
rd_stat_i  input  1  read command pulse (MIICOMMAND[1])
wr_ctrl_i  input  1  write command pulse (MIICOMMAND[2])
fiad_i  input  5  PHY address (MIIADDRESS[4:0])
rgad_i  input  5  register address (MIIADDRESS[12:8])
ctrl_data_i  input  16  write data (MIITX_DATA)
prsd_o  output  16  last read data (MIIRX_DATA)
busy_o  output  1  frame in progress
nvalid_o  output  1  scan data not yet valid
linkfail_o  output  1  link failure (from PHY reg 1)
mdc_o  output  1  MDC
mdo_o  output  1  MDIO output value
mdo_en_o  output  1  MDIO output enable (1 = drive)
mdi_i  input  1  MDIO input

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE and counters clear. Reset mid-frame aborts immediately with MDC low and MDIO released.
- Half-period H = max(clkdiv_i>>1, 1) clk cycles, latched at frame start. One bit slot = 2H cycles: MDC low for H, then high for H.
- mdc_o is low in IDLE. It toggles only while busy_o = 1.
- mdo_o/mdo_en_o change only on the first cycle of a slot (MDC low phase). mdi_i is sampled in the cycle where mdc_o goes 0->1.
- Command acceptance happens only in IDLE with cke_i = 1.
  - Priority is wr_ctrl_i > rd_stat_i > scan_stat_i.
  - Accepting a command latches fiad_i, rgad_i, ctrl_data_i, op and H.
  - busy_o rises the next cycle.
  - rd/wr pulses arriving while busy_o = 1 are dropped.
- FSM: IDLE -> PRE (PREAMBLE_LEN slots of '1'; skipped when no_pre_i = 1) -> CMD -> TA -> DATA -> END -> IDLE.
  - CMD: 14 slots, MSB first: ST = 01, OP (write 01, read 10), PHYAD[4:0], REGAD[4:0].
  - TA: write drives 1,0. Read releases the bus (mdo_en_o = 0) for both slots.
  - DATA: 16 slots, MSB first. Write drives ctrl data. Read shifts mdi_i into a shift register with mdo_en_o = 0.
  - END: one slot with MDC low and bus released, then busy_o falls.
- Frame length is 32+32 = 64 slots with preamble, 32 without, plus the 1 END slot.
- Read completion, on END entry:
  - prsd_o <= shift register.
  - If the latched rgad = 1, linkfail_o <= ~data[2].
  - If the frame came from scan, nvalid_o <= 0.
- Scan:
  - scan_stat_i 0->1 (edge seen in any state) sets nvalid_o = 1.
  - While scan_stat_i = 1 and no rd/wr pulse is pending, IDLE immediately starts a new read frame.
  - Deasserting scan_stat_i lets the current frame finish, then the FSM stays in IDLE. nvalid_o keeps its value.
- A rd/wr pulse that coincides with a scan restart wins the frame slot. Scan resumes afterwards.
- clkdiv_i or address changes mid-frame have no effect until the next frame.

Test Plan:
- Write, clkdiv_i = 4 (H = 2), fiad = 1, rgad = 0, data 0x1140, preamble on -> busy_o high for exactly 260 cycles. Decoded MDIO bits = 32 ones, then 01, 01, 00001, 00000, 10, then 0x1140. mdo_en_o is high for all data slots.
- Read reg 1, no_pre_i = 1, PHY model returns 0x796D -> busy 132 cycles, prsd_o = 0x796D, linkfail_o = 0, mdo_en_o = 0 during TA and DATA. Repeat with 0x7969 -> linkfail_o = 1.
- Scan on rgad = 1, clkdiv_i = 0 (H = 1) -> nvalid_o = 1 until the end of the first frame, then 0. Back-to-back frames continue. Drop scan mid-frame -> that frame completes, then IDLE.
- wr_ctrl_i and rd_stat_i pulsed in the same cycle -> only the write frame is sent. A rd pulse while busy -> ignored, no second frame.
- rst_i asserted at slot 40 of a write -> next cycle all outputs are 0. A new read issued afterwards completes correctly.
- cke_i held low for 10 cycles mid-frame -> mdc_o/mdo_o frozen, and frame duration is extended by exactly 10 cycles.
